// File: rtl/uart_rx.sv
// UART receiver: two-flop synchronised RX pin, mid-bit sampling, LSB-first
// deserialisation, one-cycle valid / frame-error / break strobes.
module uart_rx #(
    parameter int unsigned BIT_RATE     = 9600,
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned PAYLOAD_BITS = 8,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    output logic                    uart_rx_valid,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data,
    output logic                    uart_rx_frame_err,
    output logic                    uart_rx_break
);

    localparam int unsigned BIT_PERIOD_NS  = 1_000_000_000 / BIT_RATE;
    localparam int unsigned CLK_PERIOD_NS  = 1_000_000_000 / CLK_HZ;
    localparam int unsigned CYCLES_PER_BIT = BIT_PERIOD_NS / CLK_PERIOD_NS;
    localparam int unsigned HALF_BIT       = CYCLES_PER_BIT / 2;
    localparam int unsigned CNT_W          = 1 + $clog2(CYCLES_PER_BIT);
    localparam int unsigned BIT_CNT_W      = 4;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_HIGH = 3'd4;

    // Reject configurations the 4-bit bit counter or the frame format cannot support
    if (STOP_BITS == 0 || PAYLOAD_BITS < 2 || PAYLOAD_BITS > 15) begin : g_bad_cfg
        $error("uart_rx: unsupported STOP_BITS/PAYLOAD_BITS");
    end

    logic                    rxd_m;
    logic                    rxd_s;
    logic [2:0]              state;
    logic [2:0]              next_state;
    logic [CNT_W-1:0]        cyc_cnt;
    logic [BIT_CNT_W-1:0]    bit_cnt;
    logic [PAYLOAD_BITS-1:0] shreg;

    logic half_tick_c;
    logic bit_tick_c;
    logic last_bit_c;
    logic cyc_clr_c;
    logic shift_en_c;
    logic load_data_c;
    logic valid_d_c;
    logic ferr_d_c;
    logic brk_d_c;

    assign half_tick_c = (cyc_cnt == CNT_W'(HALF_BIT - 1));
    assign bit_tick_c  = (cyc_cnt == CNT_W'(CYCLES_PER_BIT - 1));
    assign last_bit_c  = (bit_cnt == BIT_CNT_W'(PAYLOAD_BITS - 1));

    // Two-flop synchroniser for the asynchronous RX pin, idle-high after reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= uart_rxd;
            rxd_s <= rxd_m;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        next_state  = state;
        cyc_clr_c   = 1'b0;
        shift_en_c  = 1'b0;
        load_data_c = 1'b0;
        valid_d_c   = 1'b0;
        ferr_d_c    = 1'b0;
        brk_d_c     = 1'b0;
        case (state)
            IDLE: begin
                if (!rxd_s && uart_rx_en) begin
                    next_state = START;
                    cyc_clr_c  = 1'b1;
                end
            end
            START: begin
                // Still low at mid start bit: real start; otherwise a glitch
                if (half_tick_c) begin
                    cyc_clr_c  = 1'b1;
                    next_state = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_tick_c) begin
                    cyc_clr_c  = 1'b1;
                    shift_en_c = 1'b1;
                    if (last_bit_c) begin
                        next_state = STOP;
                    end
                end
            end
            STOP: begin
                // Return to IDLE at mid stop bit so a back-to-back start is caught
                if (bit_tick_c) begin
                    cyc_clr_c = 1'b1;
                    if (rxd_s) begin
                        load_data_c = 1'b1;
                        valid_d_c   = 1'b1;
                        next_state  = IDLE;
                    end else begin
                        ferr_d_c   = 1'b1;
                        brk_d_c    = (shreg == '0);
                        next_state = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // Held-low line must release before another start is accepted
                if (rxd_s) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Bit-period cycle counter, parked at zero while waiting for a start
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cyc_cnt <= '0;
        end else if (cyc_clr_c || state == IDLE || state == WAIT_HIGH) begin
            cyc_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
        end
    end

    // Received-bit counter, cleared during the start bit
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bit_cnt <= '0;
        end else if (state == START) begin
            bit_cnt <= '0;
        end else if (shift_en_c) begin
            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
        end
    end

    // Right-shift deserialiser: first bit received ends up at bit 0
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shreg <= '0;
        end else if (shift_en_c) begin
            shreg <= {rxd_s, shreg[PAYLOAD_BITS-1:1]};
        end
    end

    // Registered word and one-cycle status strobes
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            uart_rx_data      <= '0;
            uart_rx_valid     <= 1'b0;
            uart_rx_frame_err <= 1'b0;
            uart_rx_break     <= 1'b0;
        end else begin
            if (load_data_c) begin
                uart_rx_data <= shreg;
            end
            uart_rx_valid     <= valid_d_c;
            uart_rx_frame_err <= ferr_d_c;
            uart_rx_break     <= brk_d_c;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 50 MHz / 1 Mbit/s (50 cycles per bit).
module tb_uart_rx;

    localparam int unsigned CPB = 50;

    logic       clk;
    logic       resetn;
    logic       uart_rxd;
    logic       uart_rx_en;
    logic       uart_rx_valid;
    logic [7:0] uart_rx_data;
    logic       uart_rx_frame_err;
    logic       uart_rx_break;

    int unsigned n_vec;
    int unsigned n_bad;
    int unsigned cyc;
    int unsigned last_fall;
    int unsigned n_valid;
    int unsigned n_ferr;
    int unsigned n_brk;
    int unsigned n_excl;
    int unsigned n_brk_alone;
    int unsigned n_wide;
    logic        prev_valid;
    logic        prev_ferr;
    logic [7:0]  data_q[$];
    int unsigned vcyc_q[$];

    uart_rx #(
        .BIT_RATE    (1_000_000),
        .CLK_HZ      (50_000_000),
        .PAYLOAD_BITS(8),
        .STOP_BITS   (1)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .uart_rxd         (uart_rxd),
        .uart_rx_en       (uart_rx_en),
        .uart_rx_valid    (uart_rx_valid),
        .uart_rx_data     (uart_rx_data),
        .uart_rx_frame_err(uart_rx_frame_err),
        .uart_rx_break    (uart_rx_break)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (uart_rx_valid) begin
            n_valid++;
            data_q.push_back(uart_rx_data);
            vcyc_q.push_back(cyc);
        end
        if (uart_rx_frame_err) n_ferr++;
        if (uart_rx_break) n_brk++;
        if (uart_rx_valid && uart_rx_frame_err) n_excl++;
        if (uart_rx_break && !uart_rx_frame_err) n_brk_alone++;
        if ((uart_rx_valid && prev_valid) || (uart_rx_frame_err && prev_ferr)) n_wide++;
        prev_valid = uart_rx_valid;
        prev_ferr  = uart_rx_frame_err;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] q_data(input int unsigned i);
        return (data_q.size() > i) ? 32'(data_q[i]) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] q_cyc(input int unsigned i);
        return (vcyc_q.size() > i) ? vcyc_q[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame LSB first; called and returns on a falling edge
    task automatic send_frame(input logic [7:0] d, input logic stop);
        uart_rxd  = 1'b0;
        last_fall = cyc;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = d[i];
            idle(CPB);
        end
        uart_rxd = stop;
        idle(CPB);
    endtask

    int unsigned vb;
    int unsigned fb;
    int unsigned bb;
    int unsigned fall0;
    int unsigned lat;

    initial begin
        n_vec = 0; n_bad = 0; cyc = 0; last_fall = 0;
        n_valid = 0; n_ferr = 0; n_brk = 0;
        n_excl = 0; n_brk_alone = 0; n_wide = 0;
        prev_valid = 1'b0; prev_ferr = 1'b0;
        uart_rxd = 1'b1; uart_rx_en = 1'b1; resetn = 1'b0;

        // Reset state
        idle(5);
        check("rst_valid", 32'(uart_rx_valid), 0);
        check("rst_data", 32'(uart_rx_data), 0);
        check("rst_ferr", 32'(uart_rx_frame_err), 0);
        check("rst_brk", 32'(uart_rx_break), 0);
        resetn = 1'b1;
        idle(20);
        check("post_rst_strobes", n_valid + n_ferr + n_brk, 0);

        // Single frame 0x55 with latency
        vb = n_valid; fb = n_ferr;
        send_frame(8'h55, 1'b1);
        idle(20);
        check("f55_cnt", n_valid - vb, 1);
        check("f55_data", q_data(vb), 32'h55);
        check("f55_ferr", n_ferr - fb, 0);
        lat = q_cyc(vb) - last_fall;
        check("f55_lat_in_476_479", 32'(lat >= 476 && lat <= 479), 1);
        check("f55_data_hold", 32'(uart_rx_data), 32'h55);

        // Back-to-back 0xA3, 0x0F with no idle gap
        vb = n_valid;
        send_frame(8'hA3, 1'b1);
        fall0 = last_fall;
        send_frame(8'h0F, 1'b1);
        idle(20);
        check("b2b_cnt", n_valid - vb, 2);
        check("b2b_data0", q_data(vb), 32'hA3);
        check("b2b_data1", q_data(vb + 1), 32'h0F);
        check("b2b_spacing", q_cyc(vb + 1) - q_cyc(vb), 500);
        check("b2b_fall_gap", last_fall - fall0, 500);

        // Short low glitch on an idle line, then a good frame
        vb = n_valid; fb = n_ferr; bb = n_brk;
        uart_rxd = 1'b0;
        idle(10);
        uart_rxd = 1'b1;
        idle(100);
        check("glitch_strobes", (n_valid - vb) + (n_ferr - fb) + (n_brk - bb), 0);
        send_frame(8'h3C, 1'b1);
        idle(20);
        check("glitch_next_cnt", n_valid - vb, 1);
        check("glitch_next_data", q_data(vb), 32'h3C);

        // Break: 0x00 with low stop bit, line held low 2000 cycles
        vb = n_valid; fb = n_ferr; bb = n_brk;
        send_frame(8'h00, 1'b0);
        idle(2000);
        check("brk_hold_ferr", n_ferr - fb, 1);
        uart_rxd = 1'b1;
        idle(100);
        check("brk_ferr", n_ferr - fb, 1);
        check("brk_brk", n_brk - bb, 1);
        check("brk_valid", n_valid - vb, 0);
        check("brk_data_kept", 32'(uart_rx_data), 32'h3C);

        // Framing error without break, then recovery
        vb = n_valid; fb = n_ferr; bb = n_brk;
        send_frame(8'h81, 1'b0);
        uart_rxd = 1'b1;
        idle(100);
        check("fe81_ferr", n_ferr - fb, 1);
        check("fe81_brk", n_brk - bb, 0);
        check("fe81_valid", n_valid - vb, 0);
        send_frame(8'h7E, 1'b1);
        idle(20);
        check("rec7e_cnt", n_valid - vb, 1);
        check("rec7e_data", q_data(vb), 32'h7E);

        // Reset in the middle of the data bits of 0xC6
        vb = n_valid; fb = n_ferr; bb = n_brk;
        fork
            send_frame(8'hC6, 1'b1);
            begin
                idle(200);
                resetn = 1'b0;
                #1;
                check("mid_rst_valid", 32'(uart_rx_valid), 0);
                check("mid_rst_data", 32'(uart_rx_data), 0);
                check("mid_rst_ferr", 32'(uart_rx_frame_err), 0);
                check("mid_rst_brk", 32'(uart_rx_break), 0);
            end
        join
        resetn = 1'b1;
        idle(100);
        check("mid_rst_strobes", (n_valid - vb) + (n_ferr - fb) + (n_brk - bb), 0);

        // Receiver disabled for a whole 0x99 frame
        uart_rx_en = 1'b0;
        send_frame(8'h99, 1'b1);
        idle(100);
        check("dis_strobes", (n_valid - vb) + (n_ferr - fb) + (n_brk - bb), 0);
        check("dis_data", 32'(uart_rx_data), 0);

        // Enable dropped mid-frame does not abort the frame
        uart_rx_en = 1'b1;
        fork
            send_frame(8'h5A, 1'b1);
            begin
                idle(100);
                uart_rx_en = 1'b0;
            end
        join
        idle(20);
        check("en_drop_cnt", n_valid - vb, 1);
        check("en_drop_data", q_data(vb), 32'h5A);
        uart_rx_en = 1'b1;

        // Strobe relationships over the whole run
        check("valid_ferr_excl", n_excl, 0);
        check("brk_implies_ferr", n_brk_alone, 0);
        check("strobe_width", n_wide, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
